// File: rtl/reg_arb_pkg.sv
// Shared constants for the reg_file write-port arbiter and its scan timer.
// No logic; parameter defaults and requester index encoding only.
// Build option REG_ARB_FIXED_PRIO_EN is consumed by reg_port_arbiter.
package reg_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int SCAN_CNT_W = 32;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/reg_scan_timer.sv
// Steps the reg_file second read address once every SCAN_LIMIT+1 cycles.
// Latency: scan_addr and scan_tick are registered, updated on the terminal count edge.
// Backpressure: scan_hold freezes counter and address and suppresses the tick.
module reg_scan_timer
    import reg_arb_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int unsigned SCAN_LIMIT = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_hold,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_tick
);

    logic [SCAN_CNT_W-1:0] scan_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            scan_addr <= '0;
            scan_tick <= 1'b0;
        end else if (scan_hold) begin
            scan_tick <= 1'b0;
        end else if (scan_cnt == SCAN_CNT_W'(SCAN_LIMIT)) begin
            // address wraps naturally at 2^ADDR_W
            scan_cnt  <= '0;
            scan_addr <= scan_addr + ADDR_W'(1);
            scan_tick <= 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_CNT_W'(1);
            scan_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing the reg_file write port between two requesters, plus raddr2 scan.
// Latency: one cycle from accepted request to registered wen/waddr/wdata.
// Backpressure: loser sees ready=0 and wins next cycle; REG_ARB_FIXED_PRIO_EN makes req0 always win.
module reg_port_arbiter
    import reg_arb_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int unsigned SCAN_LIMIT = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic              scan_hold,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_tick
);

    logic ptr;
    logic grant0;
    logic grant1;

    // Grants are masked by rst so nothing is accepted while reset is asserted.
    always_comb begin
        grant0 = !rst && req0_valid && (!req1_valid || (ptr == REQ0));
        grant1 = !rst && req1_valid && (!req0_valid || (ptr == REQ1));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= REQ0;
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wen <= grant0 | grant1;
            if (grant0) begin
                waddr <= req0_addr;
                wdata <= req0_data;
            end else if (grant1) begin
                waddr <= req1_addr;
                wdata <= req1_data;
            end
`ifdef REG_ARB_FIXED_PRIO_EN
            ptr <= REQ0;
`else
            if (grant0) begin
                ptr <= REQ1;
            end else if (grant1) begin
                ptr <= REQ0;
            end
`endif
        end
    end

    reg_scan_timer #(
        .ADDR_W     (ADDR_W),
        .SCAN_LIMIT (SCAN_LIMIT)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .scan_hold (scan_hold),
        .scan_addr (scan_addr),
        .scan_tick (scan_tick)
    );

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter (ADDR_W=2, SCAN_LIMIT=3): write scoreboard plus directed scan checks.
// Honours REG_ARB_FIXED_PRIO_EN for the both-valid expectations.
module tb_reg_port_arbiter;

    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 32;
    localparam int SCAN_LIMIT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              scan_hold;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_tick;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    always #5 clk = ~clk;

    reg_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SCAN_LIMIT (SCAN_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .scan_hold  (scan_hold),
        .scan_addr  (scan_addr),
        .scan_tick  (scan_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write waddr=%0h wdata=%0h at %0t", waddr, wdata, $time);
            end else begin
                chk("sb_waddr", 32'(waddr), 32'(exp_addr_q.pop_front()));
                chk("sb_wdata", wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        scan_hold  = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 2'd1;
        req0_data  = 32'h11;
        req1_valid = 1'b0;
        req1_addr  = 2'd2;
        req1_data  = 32'h22;
        #1 rst = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_scan_addr", 32'(scan_addr), 32'd0);
        chk("rst_scan_tick", 32'(scan_tick), 32'd0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single req0 write, one cycle of valid
        req0_valid = 1'b1;
        req0_addr  = 2'd3;
        req0_data  = 32'hA5;
        exp_addr_q.push_back(2'd3);
        exp_data_q.push_back(32'hA5);
        @(negedge clk);
        chk("single_ready0", 32'(req0_ready), 32'd1);
        chk("single_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("single_wen_drop", 32'(wen), 32'd0);

        // Reset mid-transfer: in-flight write dropped, no scoreboard entry pushed
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_addr  = 2'd1;
        req0_data  = 32'h11;
        @(posedge clk);
        #1;
        chk("midrst_wen_before", 32'(wen), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_wen", 32'(wen), 32'd0);
        chk("midrst_ready0", 32'(req0_ready), 32'd0);
        chk("midrst_scan_addr", 32'(scan_addr), 32'd0);

        // Both valid continuously, starting fresh from reset
        req1_valid = 1'b1;
`ifdef REG_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(2'd1);
            exp_data_q.push_back(32'h11);
        end
`else
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back((i % 2 == 0) ? 2'd1 : 2'd2);
            exp_data_q.push_back((i % 2 == 0) ? 32'h11 : 32'h22);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef REG_ARB_FIXED_PRIO_EN
            chk("both_ready0", 32'(req0_ready), 32'd1);
            chk("both_ready1", 32'(req1_ready), 32'd0);
`else
            chk("both_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("both_ready1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
`endif
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(exp_addr_q.size()), 32'd0);

        // Free-running scan: tick every 4 cycles, address wraps 3 -> 0
        pulse_reset();
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("scan_addr", 32'(scan_addr), 32'((j / 4) % 4));
            chk("scan_tick", 32'(scan_tick), (j % 4 == 0) ? 32'd1 : 32'd0);
        end

        // Hold with counter frozen at 2, then resume
        pulse_reset();
        repeat (2) @(posedge clk);
        #1 scan_hold = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_addr", 32'(scan_addr), 32'd0);
            chk("hold_tick", 32'(scan_tick), 32'd0);
        end
        #1 scan_hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("resume_addr_a", 32'(scan_addr), 32'd0);
        chk("resume_tick_a", 32'(scan_tick), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("resume_addr_b", 32'(scan_addr), 32'd1);
        chk("resume_tick_b", 32'(scan_tick), 32'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
